// File: rtl/regfile_board_ctrl_if.sv
// Register-file bus between the board controller and the banked
// register file: read/write addresses, write data, strobes and read data.
interface regfile_board_ctrl_if;
    logic [3:0]  r_addr_a;
    logic [3:0]  r_addr_b;
    logic [3:0]  r_addr_c;
    logic [31:0] r_data_a;
    logic [31:0] r_data_b;
    logic [31:0] r_data_c;
    logic [4:0]  M;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] pc_data;
    logic        write_reg;
    logic        write_pc;
    logic        reg_we;

    modport master (
        output r_addr_a, r_addr_b, r_addr_c,
        output M, w_addr, w_data, pc_data,
        output write_reg, write_pc, reg_we,
        input  r_data_a, r_data_b, r_data_c
    );

    modport slave (
        input  r_addr_a, r_addr_b, r_addr_c,
        input  M, w_addr, w_data, pc_data,
        input  write_reg, write_pc, reg_we,
        output r_data_a, r_data_b, r_data_c
    );
endinterface

// File: rtl/regfile_board_ctrl.sv
// Board controller: debounces buttons, loads config from switches,
// sequences write/settle/capture on the register file and feeds the display.
module regfile_board_ctrl #(
    parameter int DB_CYCLES     = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 sw,
    input  logic                        key_sel,
    input  logic                        key_load,
    input  logic                        key_commit,
    input  logic                        key_disp,
    input  logic                        key_clr,
    regfile_board_ctrl_if.master        rf,
    output logic [1:0]                  load_field,
    output logic [2:0]                  disp_sel,
    output logic [31:0]                 disp_data,
    output logic                        busy
);
    localparam int CW  = $clog2(DB_CYCLES) + 1;
    localparam int SCW = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, CAPTURE} state_t;

    logic [4:0]    key_raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    lvl;
    logic [4:0]    lvl_d;
    logic [4:0]    pulse;
    logic [CW-1:0] db_cnt [5];

    logic sel_p, load_p, commit_p, disp_p, clr_p;

    state_t           state_q;
    state_t           state_d;
    logic [SCW-1:0]   set_cnt;
    logic             settle_done;
    logic             capture;

    logic [31:0] shadow_a;
    logic [31:0] shadow_b;
    logic [31:0] shadow_c;

    assign key_raw = {key_clr, key_disp, key_commit, key_load, key_sel};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulse    = lvl & ~lvl_d;
    assign sel_p    = pulse[0];
    assign load_p   = pulse[1];
    assign commit_p = pulse[2];
    assign disp_p   = pulse[3];
    assign clr_p    = pulse[4];

    assign settle_done = (set_cnt == SCW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rf.reg_we = 1'b0;
        capture   = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (commit_p)
                    state_d = (rf.write_reg | rf.write_pc) ? WRITE : SETTLE;
            end
            WRITE: begin
                rf.reg_we = 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (settle_done) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr_p) begin
            state_d = IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q != SETTLE) set_cnt <= '0;
        else                          set_cnt <= set_cnt + 1'b1;
    end

    // Loads and selects only act in IDLE; a commit in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            rf.r_addr_a  <= '0;
            rf.r_addr_b  <= '0;
            rf.r_addr_c  <= '0;
            rf.M         <= '0;
            rf.w_addr    <= '0;
            rf.write_reg <= 1'b0;
            rf.write_pc  <= 1'b0;
            rf.w_data    <= '0;
            rf.pc_data   <= '0;
            shadow_a     <= '0;
            shadow_b     <= '0;
            shadow_c     <= '0;
            load_field   <= '0;
            disp_sel     <= '0;
        end else begin
            if (disp_p)
                disp_sel <= (disp_sel == 3'd5) ? 3'd0 : disp_sel + 3'd1;
            if (capture) begin
                shadow_a <= rf.r_data_a;
                shadow_b <= rf.r_data_b;
                shadow_c <= rf.r_data_c;
            end
            if (!busy && !commit_p) begin
                if (load_p) begin
                    case (load_field)
                        2'd0: begin
                            rf.r_addr_a  <= sw[31:28];
                            rf.r_addr_b  <= sw[27:24];
                            rf.r_addr_c  <= sw[23:20];
                            rf.M         <= sw[19:15];
                            rf.w_addr    <= sw[11:8];
                            rf.write_reg <= sw[1];
                            rf.write_pc  <= sw[0];
                        end
                        2'd1:    rf.w_data  <= sw;
                        2'd2:    rf.pc_data <= sw;
                        default: ;
                    endcase
                end
                if (sel_p)
                    load_field <= (load_field == 2'd2) ? 2'd0 : load_field + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data <= '0;
        end else begin
            case (disp_sel)
                3'd1:    disp_data <= shadow_a;
                3'd2:    disp_data <= shadow_b;
                3'd3:    disp_data <= shadow_c;
                3'd4:    disp_data <= rf.pc_data;
                3'd5:    disp_data <= 32'h8888_8888;
                default: disp_data <= 32'h0000_0000;
            endcase
        end
    end
endmodule

// File: doc/regfile_board_ctrl.md
# regfile_board_ctrl

Synchronous board-level controller that sequences the banked register file from the FPGA test board's switches and push-buttons, replacing ad-hoc button-clocked logic with a single clocked design. It debounces the buttons and loads the register-file control word, write data and PC data from the 32 switches. It issues a one-cycle write strobe, waits for the read ports to settle, captures the read data and drives a selected word to the seven-segment display driver. It sits between the board I/O and the `registers` / `Display` instances.

## Interface
- DB_CYCLES, 16, consecutive stable cycles required before a button level is accepted (board build overrides to 1_000_000)
- SETTLE_CYCLES, 2, cycles waited after a write before read data is captured (≥1)
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- sw  in  32  switch bank, sw[31] is the leftmost switch
- key_sel, key_load, key_commit, key_disp, key_clr  in  1 each  raw asynchronous push-buttons, active-high
- r_data_a, r_data_b, r_data_c  in  32 each  register-file read ports
- r_addr_a, r_addr_b, r_addr_c  out  4 each  read addresses
- M  out  5  processor mode for bank select
- w_addr  out  4  write address
- w_data  out  32  write data
- pc_data  out  32  PC write data
- write_reg, write_pc  out  1 each  write-enable levels from the control word
- reg_we  out  1  one-cycle write strobe to the register file (its clock-enable)
- load_field  out  2  currently selected load target
- disp_sel  out  3  currently selected display source
- disp_data  out  32  word to the display driver
- busy  out  1  high while the FSM is not in IDLE

## Operation
- Each key has a 2-flop synchronizer and a debounce counter. The debounced level updates after DB_CYCLES consecutive identical synchronized samples. A rising edge of the debounced level produces a one-cycle pulse (`*_p`).
- load_field cycles 0→1→2→0 on sel_p.
- On load_p, sw is latched into the selected field:
  - Field 0 (control word): r_addr_a=sw[31:28], r_addr_b=sw[27:24], r_addr_c=sw[23:20], M=sw[19:15], w_addr=sw[11:8], write_reg=sw[1], write_pc=sw[0]. Other bits are ignored.
  - Field 1: w_data=sw.
  - Field 2: pc_data=sw.
- disp_sel cycles 0..5 and wraps 5→0 on disp_p. disp_data is registered and selects:
  - 0: 0x0000_0000
  - 1: shadow_a
  - 2: shadow_b
  - 3: shadow_c
  - 4: pc_data
  - 5: 0x8888_8888
- FSM states and transitions:
  - IDLE: commit_p goes to WRITE if write_reg|write_pc, else to SETTLE.
  - WRITE: reg_we=1 for exactly this cycle, then SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then CAPTURE.
  - CAPTURE: shadow_a/b/c ← r_data_a/b/c, then IDLE.
- A commit with both write enables at 0 therefore acts as a read-refresh.
- While busy, load_p, sel_p and commit_p are dropped. disp_p is honoured in every state.
- clr_p in any state: FSM goes to IDLE, and all config registers, shadows, load_field and disp_sel are cleared. The debouncers are not reset.
- Same-cycle priority: clr > commit > load > sel. When load_p and sel_p coincide, the load uses the pre-increment field.

## Timing
- Reset values: all outputs 0, FSM in IDLE, debounced levels 0, debounce counters 0.
- Button to pulse latency: 2 sync cycles + DB_CYCLES + 1 cycle.
- Config outputs update the cycle after load_p.
- disp_data updates one cycle after disp_sel or a shadow changes.
- Commit with a write, with commit_p in cycle t:
  - WRITE at t+1 (reg_we high at t+1 only).
  - SETTLE for t+2..t+1+SETTLE_CYCLES.
  - CAPTURE at t+2+SETTLE_CYCLES.
  - Shadows valid at t+3+SETTLE_CYCLES.
  - busy high from t+1 through the CAPTURE cycle.
- Read-only commit: the same sequence without the WRITE cycle, so everything is one cycle earlier.
- The write-address outputs are stable throughout WRITE because loads are blocked while busy.
- A reset in the middle of a sequence aborts it immediately: reg_we=0 on the next edge and no capture occurs.

## Test plan
- Reset, then pulse key_disp 7 times → disp_sel visits 1,2,3,4,5,0,1. At disp_sel=5, disp_data=0x8888_8888; at disp_sel=0, disp_data=0.
- Set sw=0x1230_0002, press load (field 0) → r_addr_a=1, r_addr_b=2, r_addr_c=3, M=0, write_reg=1, write_pc=0. Then sel + sw=0xDEAD_BEEF + load → w_data=0xDEAD_BEEF.
- Commit with write_reg=1 → reg_we high for exactly 1 cycle. busy lasts 2+SETTLE_CYCLES cycles. Given a register model returning 0xDEAD_BEEF on port a, disp_sel=1 shows 0xDEAD_BEEF.
- Hold key_commit with 3-cycle glitches (DB_CYCLES=16) → no pulse. A stable press → exactly one commit, and no second commit while the key remains held.
- Press load while busy → config unchanged. Assert clr during SETTLE → busy=0 next cycle, shadows=0, no CAPTURE.
- Assert rst during WRITE → reg_we=0 and all outputs 0 after the edge. Assert load_p and sel_p in the same cycle → old field loaded and load_field increments.
